// File: rtl/sha3_pkg.sv
// sha3_pkg: Keccak state type, digest lengths, MODE encoding and the word-count helper
// shared by the AXI-Stream digest transmitter.
package sha3_pkg;

   localparam int unsigned STATE_BITS = 1600;

   localparam int unsigned DIGEST_224 = 224;
   localparam int unsigned DIGEST_256 = 256;
   localparam int unsigned DIGEST_384 = 384;
   localparam int unsigned DIGEST_512 = 512;

   typedef logic [0:4][0:4][63:0] sha3_state_t;

   typedef enum logic [1:0] {
      Mode224 = 2'd0,
      Mode256 = 2'd1,
      Mode384 = 2'd2,
      Mode512 = 2'd3
   } digest_mode_e;

   typedef enum logic {
      StIdle,
      StSend
   } tx_state_e;

   function automatic int unsigned digest_len(input logic [1:0] mode);
      case (digest_mode_e'(mode))
         Mode224: return DIGEST_224;
         Mode256: return DIGEST_256;
         Mode384: return DIGEST_384;
         default: return DIGEST_512;
      endcase
   endfunction

   // Number of stream words needed to carry the digest, rounding the tail word up.
   function automatic int unsigned num_words(input logic [1:0] mode,
                                             input int unsigned data_width);
      return (digest_len(mode) + data_width - 1) / data_width;
   endfunction

endpackage

// File: rtl/axis_word_mux.sv
// axis_word_mux: picks word k out of the flattened 1600-bit snapshot and zeroes every bit
// that lies at or beyond digest_bits.
module axis_word_mux
   import sha3_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic [STATE_BITS-1:0] snapshot,
   input  logic [7:0]            k,
   input  logic [10:0]           digest_bits,
   output logic [DATA_WIDTH-1:0] word
);

   logic [31:0]           base;
   logic [DATA_WIDTH-1:0] mask;

   always_comb begin
      base = 32'(k) * DATA_WIDTH;
      // A shift of DATA_WIDTH or more leaves all ones: word lies fully inside the digest.
      if (32'(digest_bits) <= base) begin
         mask = '0;
      end else begin
         mask = ~({DATA_WIDTH{1'b1}} << (32'(digest_bits) - base));
      end
      word = DATA_WIDTH'(snapshot >> base) & mask;
   end

endmodule

// File: rtl/axis_digest_tx.sv
// axis_digest_tx: snapshots a Keccak state on START and streams the digest as AXI-Stream words.
// Define AXIS_TX_FULL_STATE_EN to add FULL_STATE, which streams all 1600 state bits unmasked.
module axis_digest_tx
   import sha3_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [0:4][0:4][63:0] D_in,
   input  logic                  START,
   input  logic [1:0]            MODE,
   input  logic                  TREADY,
`ifdef AXIS_TX_FULL_STATE_EN
   input  logic                  FULL_STATE,
`endif
   output logic [DATA_WIDTH-1:0] TDATA,
   output logic                  TVALID,
   output logic                  TLAST,
   output logic [7:0]            TDEST,
   output logic                  BUSY
);

   tx_state_e             state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            mode_q, mode_d;
   logic [STATE_BITS-1:0] snap_q, snap_d;
   logic [STATE_BITS-1:0] d_flat;
   logic [10:0]           digest_bits;
   logic [7:0]            n_words;
   logic [DATA_WIDTH-1:0] word;
`ifdef AXIS_TX_FULL_STATE_EN
   logic                  full_q, full_d;
`endif

   // Lane (x,y) sits at flat offset 64*(5y+x), which differs from its packed-array position.
   always_comb begin
      d_flat = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            d_flat[64*(5*y+x) +: 64] = D_in[x][y];
         end
      end
   end

   always_comb begin
      digest_bits = 11'(digest_len(mode_q));
      n_words     = 8'(num_words(mode_q, DATA_WIDTH));
`ifdef AXIS_TX_FULL_STATE_EN
      if (full_q) begin
         digest_bits = 11'(STATE_BITS);
         n_words     = 8'(STATE_BITS / DATA_WIDTH);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      snap_d  = snap_q;
`ifdef AXIS_TX_FULL_STATE_EN
      full_d  = full_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (START) begin
               snap_d  = d_flat;
               mode_d  = MODE;
               cnt_d   = '0;
`ifdef AXIS_TX_FULL_STATE_EN
               full_d  = FULL_STATE;
`endif
               state_d = StSend;
            end
         end
         StSend: begin
            // START is deliberately ignored here, even on the final transfer edge.
            if (TREADY) begin
               if (cnt_q == n_words - 8'd1) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mode_q  <= '0;
         snap_q  <= '0;
`ifdef AXIS_TX_FULL_STATE_EN
         full_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         snap_q  <= snap_d;
`ifdef AXIS_TX_FULL_STATE_EN
         full_q  <= full_d;
`endif
      end
   end

   axis_word_mux #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_word_mux (
      .snapshot   (snap_q),
      .k          (cnt_q),
      .digest_bits(digest_bits),
      .word       (word)
   );

   assign TVALID = (state_q == StSend);
   assign BUSY   = (state_q == StSend);
   assign TDEST  = cnt_q;
   assign TLAST  = TVALID && (cnt_q == n_words - 8'd1);
   assign TDATA  = TVALID ? word : '0;

endmodule

// File: tb/tb_axis_digest_tx.sv
// tb_axis_digest_tx: directed scenarios on 16- and 64-bit instances; expected words go into
// per-instance queues that negedge monitors compare against every presented word.
module tb_axis_digest_tx;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  dest;
      logic        last;
   } exp_t;

   logic                  aclk;
   logic                  aresetn;
   logic [0:4][0:4][63:0] d_in;
   logic [1:0]            mode;
   logic                  start16, start64, tready16, tready64;
   logic [15:0]           tdata16;
   logic [63:0]           tdata64;
   logic                  tv16, tlast16, busy16, tv64, tlast64, busy64;
   logic [7:0]            tdest16, tdest64;
`ifdef AXIS_TX_FULL_STATE_EN
   logic                  full16;
`endif

   exp_t q16[$];
   exp_t q64[$];
   exp_t e16, e64;
   int   n_cmp = 0;
   int   n_bad = 0;

   axis_digest_tx #(
      .DATA_WIDTH(16)
   ) dut16 (
      .ACLK      (aclk),
      .ARESETn   (aresetn),
      .D_in      (d_in),
      .START     (start16),
      .MODE      (mode),
      .TREADY    (tready16),
`ifdef AXIS_TX_FULL_STATE_EN
      .FULL_STATE(full16),
`endif
      .TDATA     (tdata16),
      .TVALID    (tv16),
      .TLAST     (tlast16),
      .TDEST     (tdest16),
      .BUSY      (busy16)
   );

   axis_digest_tx #(
      .DATA_WIDTH(64)
   ) dut64 (
      .ACLK      (aclk),
      .ARESETn   (aresetn),
      .D_in      (d_in),
      .START     (start64),
      .MODE      (mode),
      .TREADY    (tready64),
`ifdef AXIS_TX_FULL_STATE_EN
      .FULL_STATE(1'b0),
`endif
      .TDATA     (tdata64),
      .TVALID    (tv64),
      .TLAST     (tlast64),
      .TDEST     (tdest64),
      .BUSY      (busy64)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   // Peeks while stalled (so held words are checked too) and pops on an actual transfer.
   always @(negedge aclk) begin
      if (tv16) begin
         n_cmp++;
         if (q16.size() == 0) begin
            n_bad++;
            $display("FAIL word16_unexpected: got data=%h dest=%0d, expected no word",
                     tdata16, tdest16);
         end else begin
            e16 = q16[0];
            if (tdata16 !== e16.data[15:0] || tdest16 !== e16.dest || tlast16 !== e16.last) begin
               n_bad++;
               $display("FAIL word16: got data=%h dest=%0d last=%0b, expected data=%h dest=%0d last=%0b",
                        tdata16, tdest16, tlast16, e16.data[15:0], e16.dest, e16.last);
            end
            if (tready16) void'(q16.pop_front());
         end
      end
   end

   always @(negedge aclk) begin
      if (tv64) begin
         n_cmp++;
         if (q64.size() == 0) begin
            n_bad++;
            $display("FAIL word64_unexpected: got data=%h dest=%0d, expected no word",
                     tdata64, tdest64);
         end else begin
            e64 = q64[0];
            if (tdata64 !== e64.data || tdest64 !== e64.dest || tlast64 !== e64.last) begin
               n_bad++;
               $display("FAIL word64: got data=%h dest=%0d last=%0b, expected data=%h dest=%0d last=%0b",
                        tdata64, tdest64, tlast64, e64.data, e64.dest, e64.last);
            end
            if (tready64) void'(q64.pop_front());
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push16(input logic [63:0] data, input int dest, input bit last);
      q16.push_back('{data: data, dest: 8'(dest), last: last});
   endtask

   task automatic push64(input logic [63:0] data, input int dest, input bit last);
      q64.push_back('{data: data, dest: 8'(dest), last: last});
   endtask

   // Word k of the flattened state reads 16'hA000 + k at width 16.
   task automatic set_pattern();
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            for (int j = 0; j < 4; j++)
               d_in[x][y][16*j +: 16] = 16'hA000 + 16'((5*y + x)*4 + j);
   endtask

   task automatic issue_start16();
      start16 = 1'b1;
      @(posedge aclk); #1;
      start16 = 1'b0;
      check("start16_latency", {62'd0, tv16, busy16}, 64'd3);
   endtask

   task automatic issue_start64();
      start64 = 1'b1;
      @(posedge aclk); #1;
      start64 = 1'b0;
      check("start64_latency", {62'd0, tv64, busy64}, 64'd3);
   endtask

   // Runs until the queue empties; raises START on the TLAST word and at TDEST==start_at.
   task automatic drain16(input int budget, input bit toggle, input int start_at);
      int cyc = 0;
      while (q16.size() != 0 && cyc < budget) begin
         if (toggle) tready16 = (cyc % 4 == 0) || (cyc % 4 == 3);
         start16 = tv16 && (tlast16 || int'(tdest16) == start_at);
         @(posedge aclk); #1;
         cyc++;
      end
      start16  = 1'b0;
      tready16 = 1'b1;
      check("drain16_done", 64'(q16.size()), 64'd0);
      check("idle16_after_last", {62'd0, tv16, busy16}, 64'd0);
   endtask

   task automatic drain64(input int budget);
      int cyc = 0;
      while (q64.size() != 0 && cyc < budget) begin
         @(posedge aclk); #1;
         cyc++;
      end
      check("drain64_done", 64'(q64.size()), 64'd0);
      check("idle64_after_last", {62'd0, tv64, busy64}, 64'd0);
   endtask

   initial begin
      aresetn  = 1'b1;
      start16  = 1'b0;
      start64  = 1'b0;
      tready16 = 1'b1;
      tready64 = 1'b1;
      mode     = 2'd1;
`ifdef AXIS_TX_FULL_STATE_EN
      full16   = 1'b0;
`endif
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            d_in[x][y] = 64'hAAAA_AAAA_AAAA_AAAA;
      #1 aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("rst_tvalid", {63'd0, tv16}, 64'd0);
      check("rst_tlast", {63'd0, tlast16}, 64'd0);
      check("rst_busy", {63'd0, busy16}, 64'd0);
      check("rst_tdest", {56'd0, tdest16}, 64'd0);
      check("rst_tdata", {48'd0, tdata16}, 64'd0);
      check("rst_tvalid64", {63'd0, tv64}, 64'd0);

      // Alternating bits, MODE=1, START on the first edge after reset release.
      for (int k = 0; k < 16; k++) push16(64'hAAAA, k, k == 15);
      aresetn = 1'b1;
      issue_start16();
      drain16(100, 1'b0, 8);

      // Single lane D_in[1][0], MODE=0: words 4..7 carry it, 14 words in all.
      d_in = '0;
      d_in[1][0] = 64'h0123456789ABCDEF;
      mode = 2'd0;
      for (int k = 0; k < 14; k++) begin
         case (k)
            4:       push16(64'hCDEF, k, 1'b0);
            5:       push16(64'h89AB, k, 1'b0);
            6:       push16(64'h4567, k, 1'b0);
            7:       push16(64'h0123, k, 1'b0);
            default: push16(64'h0000, k, k == 13);
         endcase
      end
      issue_start16();
      drain16(100, 1'b0, -1);

      // MODE=3 with stalls; D_in and MODE are scrambled after the snapshot.
      set_pattern();
      mode = 2'd3;
      for (int k = 0; k < 32; k++) push16(64'(16'hA000 + 16'(k)), k, k == 31);
      issue_start16();
      d_in = '0;
      mode = 2'd0;
      drain16(300, 1'b1, -1);

      // 64-bit instance, 224-bit digest: top half of the last word is masked.
      d_in = '1;
      mode = 2'd0;
      for (int k = 0; k < 3; k++) push64(64'hFFFF_FFFF_FFFF_FFFF, k, 1'b0);
      push64(64'h0000_0000_FFFF_FFFF, 3, 1'b1);
      issue_start64();
      drain64(50);

      // Reset in the middle of a MODE=1 stream.
      set_pattern();
      mode = 2'd1;
      for (int k = 0; k < 16; k++) push16(64'(16'hA000 + 16'(k)), k, k == 15);
      issue_start16();
      for (int i = 0; i < 40 && tdest16 != 8'd5; i++) begin
         @(posedge aclk); #1;
      end
      check("s5_reach_word5", {56'd0, tdest16}, 64'd5);
      #2 aresetn = 1'b0;
      #1;
      check("s5_async_tvalid", {62'd0, tv16, busy16}, 64'd0);
      check("s5_async_tdest", {56'd0, tdest16}, 64'd0);
      check("s5_async_tdata", {48'd0, tdata16}, 64'd0);
      q16.delete();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      repeat (6) begin
         @(posedge aclk); #1;
         check("s5_quiet_after_reset", {63'd0, tv16}, 64'd0);
      end
      for (int k = 0; k < 16; k++) push16(64'(16'hA000 + 16'(k)), k, k == 15);
      issue_start16();
      drain16(100, 1'b0, -1);

`ifdef AXIS_TX_FULL_STATE_EN
      // Whole state at width 16: 100 unmasked words, START at TDEST=50 ignored.
      set_pattern();
      full16 = 1'b1;
      for (int k = 0; k < 100; k++) push16(64'(16'hA000 + 16'(k)), k, k == 99);
      issue_start16();
      full16 = 1'b0;
      drain16(400, 1'b0, 50);
`endif

      repeat (3) @(posedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_digest_tx.md
AXIS_DIGEST_TX -- requirements
Module: axis_digest_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the stream word width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have these ports, listed as name  direction  width  meaning:
- ACLK  in  1  the single clock; all logic is on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- D_in  in  [0:4][0:4][63:0]  Keccak state; lane D_in[x][y] maps to flat bits 64*(5y+x)+63 : 64*(5y+x).
- START  in  1  one-cycle request to capture D_in and stream it.
- MODE  in  2  digest size: 0=224, 1=256, 2=384, 3=512 bits.
- TREADY  in  1  downstream ready.
- TDATA  out  DATA_WIDTH  stream word.
- TVALID  out  1  TDATA valid.
- TLAST  out  1  marks the final word of the digest.
- TDEST  out  8  word index; 0 is the first word.
- BUSY  out  1  high while a transfer is in progress.

Function
REQ-003 SHALL implement a two-state FSM: IDLE and SEND.
REQ-004 In IDLE, START=1 SHALL, at that edge, snapshot D_in into an internal 1600-bit register, latch MODE, clear the word counter and enter SEND.
REQ-005 TVALID SHALL rise on the first edge after START is sampled, giving one cycle of latency; TVALID=1 exactly while in SEND.
REQ-006 The word count N SHALL equal ceil(digest_bits/DATA_WIDTH). For example, with DATA_WIDTH=16 N is 14, 16, 24 or 32, and with DATA_WIDTH=64 and MODE=0, N=4.
REQ-007 TDATA SHALL equal flat bits DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k of the snapshot, where k is the counter value; TDEST SHALL equal k.
REQ-008 In the final word, bits at or above position digest_bits SHALL be driven as zero.
REQ-009 A word SHALL transfer only on an edge where TVALID=1 and TREADY=1; the counter advances by 1 on each transfer.
REQ-010 While TVALID=1 and TREADY=0, TDATA, TDEST and TLAST SHALL hold stable.
REQ-011 TLAST SHALL be 1 only while k=N-1.
REQ-012 A transfer with TLAST=1 SHALL return the FSM to IDLE; TVALID is 0 on the next cycle.
REQ-013 A START that arrives while in SEND SHALL be ignored, including a START on the same edge as the final transfer; back-to-back messages need START in IDLE.
REQ-014 Changes to D_in or MODE during SEND SHALL NOT affect the words being sent.
REQ-015 BUSY SHALL equal (state==SEND).
REQ-016 TVALID SHALL NOT depend combinationally on TREADY.

Reset
REQ-017 ARESETn=0 SHALL asynchronously force IDLE, TVALID=0, TLAST=0, BUSY=0, TDEST=0, TDATA=0, counter=0 and snapshot=0.
REQ-018 A reset during SEND SHALL abort the transfer; no word is sent after reset deasserts until a new START.
REQ-019 START sampled on the first edge after reset deassertion SHALL be honoured.

Configuration
REQ-020 Macro AXIS_TX_FULL_STATE_EN, when defined, SHALL add input FULL_STATE (1 bit, latched with START). When FULL_STATE=1, N=1600/DATA_WIDTH, with no masking and TDEST running 0..N-1, for example 0..99 at width 16.
REQ-021 When AXIS_TX_FULL_STATE_EN is undefined, port FULL_STATE SHALL be absent and only the MODE digest lengths SHALL exist.

Structure
REQ-022 The shared package sha3_pkg SHALL hold:
- the state typedef [0:4][0:4][63:0];
- the digest-length constants 224/256/384/512;
- the MODE encoding;
- a constant function returning N from (mode, DATA_WIDTH).
REQ-023 The design SHALL contain one sub-module, axis_word_mux: combinational word selection plus tail masking from (snapshot, k, digest_bits). FSM and counter stay in axis_digest_tx.

Verification
REQ-024 The bench SHALL cover these directed scenarios at DATA_WIDTH=16 unless stated:
- Flat state with bit i = i[0]; START, MODE=1, TREADY=1 -> 16 words, each TDATA=16'hAAAA, TDEST 0..15, TLAST only on word 15, BUSY low the cycle after.
- Lane D_in[1][0]=64'h0123456789ABCDEF, MODE=0, TREADY=1 -> words 4..7 = CDEF, 89AB, 4567, 0123; 14 words total.
- MODE=3, TREADY toggling 1,0,0,1 repeating -> 32 transfers; TDATA/TDEST stable during each stall; order unchanged.
- DATA_WIDTH=64, MODE=0, all-ones state -> 4 words, final TDATA=64'h00000000FFFFFFFF with TLAST=1.
- ARESETn pulsed low at word 5 of MODE=1 -> TVALID falls immediately; after release no output until START; a new START yields a full 16-word stream from TDEST=0.
- With AXIS_TX_FULL_STATE_EN, FULL_STATE=1 -> 100 words, TLAST on TDEST=99; a START issued at TDEST=50 has no effect.
